clkdiv_prog: RTL and testbench
==============================

Name: clkdiv_prog

Overview:
- Runtime-programmable integer clock divider for the DDR3 PHY clocking path. It generalises the fixed-ratio divider to a parametrised counter width.
- Adds a runtime divisor change that is glitch-free and takes effect only at the period boundary.
- Adds a one-cycle strobe marking each divided period, and a synchronised ALIGNWD phase-slip with acknowledge.
- Fully synchronous to CLKI. Its outputs feed word-alignment logic and slow-domain clock enables.

Parameters:
- CNT_W, 4, width of the divide counter and divisor ports; maximum divisor is 2^CNT_W-1.
- DEFAULT_DIV, 4, divisor in effect after reset; must be within 2..2^CNT_W-1.

Ports:
- CLKI  in  1  fast clock; all logic on its rising edge.
- RSTN  in  1  asynchronous active-low reset.
- EN  in  1  count enable; low freezes all state.
- DIV_VAL  in  CNT_W  requested divisor.
- DIV_LD  in  1  one-cycle strobe that captures DIV_VAL.
- ALIGNWD  in  1  asynchronous slip request; each rising edge delays the output phase by one CLKI cycle.
- CDIVX  out  1  divided clock, registered.
- CDIV_STB  out  1  one-CLKI-cycle pulse on the first high cycle of each CDIVX period.
- SLIP_ACK  out  1  one-cycle pulse when a slip is executed.
- DIV_ACT  out  CNT_W  divisor currently in effect.
- PHASE  out  CNT_W  current counter value.

Behaviour:
- Reset (RSTN low, async):
  - cnt=0, CDIVX=0, CDIV_STB=0, SLIP_ACK=0.
  - DIV_ACT=DEFAULT_DIV, pending divisor=DEFAULT_DIV.
  - ALIGNWD sync/edge flops cleared to 0.
  - Asserting RSTN mid-period aborts the period immediately; no partial-pulse guarantee.
- Divisor clamp: DIV_VAL of 0 or 1 is captured as 2. Every other value is taken as-is.
- Half-length: hi = (DIV_ACT+1)>>1, so the odd-divisor duty cycle is (N+1)/2 high, (N-1)/2 low.
- Normal edge (EN=1, no slip executing), using the pre-update cnt:
  - CDIVX <= (cnt < hi).
  - CDIV_STB <= (cnt == 0).
  - cnt <= (cnt == DIV_ACT-1) ? 0 : cnt+1.
  - CDIVX and CDIV_STB therefore lag PHASE by one cycle. The first CDIVX high and STB appear on the first enabled edge after reset release.
- Divisor update:
  - DIV_LD writes the clamped DIV_VAL into the pending register.
  - On the wrap edge (cnt == DIV_ACT-1 with counting enabled), DIV_ACT <= pending.
  - If DIV_LD coincides with the wrap edge, the new DIV_VAL bypasses pending and loads straight into DIV_ACT.
  - Loads are never applied mid-period. Multiple DIV_LD within one period: the last one wins.
- Slip:
  - ALIGNWD passes through a 2-flop synchroniser plus an edge flop. A rising edge arms slip_req.
  - On the next EN=1 edge the slip executes: cnt, CDIVX and DIV_ACT hold; CDIV_STB=0; SLIP_ACK=1; slip_req clears.
  - Net effect: the period containing the slip is DIV_ACT+1 cycles long.
  - Rising ALIGNWD edges while slip_req is already armed are dropped (no queueing).
  - ALIGNWD-to-slip latency is 3 CLKI edges with EN=1: 2 synchroniser edges + 1 edge-detect edge.
- Simultaneous events:
  - Slip on what would be the wrap edge: the slip wins; cnt stays at DIV_ACT-1 and the wrap (and pending-divisor application) happens on the next edge.
  - DIV_LD during a slip edge is still captured into pending.
- EN=0: cnt, CDIVX, DIV_ACT and pending hold. DIV_LD is still captured. CDIV_STB and SLIP_ACK are forced 0. The synchroniser keeps running and slip_req stays armed.
- PHASE = cnt; DIV_ACT is driven directly from its register.
- No combinational path from any input to any output.

Test Plan:
- Reset release with DEFAULT_DIV=4, EN=1 -> CDIVX pattern 1,1,0,0 repeating from the first edge; CDIV_STB high on edges 1,5,9; PHASE 1,2,3,0,...
- Odd divide: DIV_VAL=5 with DIV_LD while PHASE=1 -> the current 4-cycle period completes, then CDIVX = 1,1,1,0,0 repeating; DIV_ACT changes to 5 exactly on the wrap edge.
- Clamp and bypass: DIV_VAL=1 with DIV_LD on the wrap edge -> DIV_ACT=2 from the next edge; CDIVX toggles every cycle; CDIV_STB every 2nd cycle.
- Slip: DIV=4, single ALIGNWD rising edge -> SLIP_ACK after 3 edges; that period is 5 cycles; later STB spacing returns to 4; a second ALIGNWD edge while armed produces no extra slip.
- Slip on wrap plus EN gating: slip on PHASE=3 -> PHASE holds 3 for one extra cycle, then 0. EN low for 3 cycles -> all outputs freeze, STB=0, and the period is extended by 3.
- Async reset mid-period (PHASE=2, DIV_ACT=7 pending 3) -> outputs 0 immediately with no clock; DIV_ACT=4 after reset; pending load discarded.

Source files
------------

// File: rtl/clkdiv_prog.sv
// Runtime-programmable integer clock divider with a period strobe, divisor updates
// that apply only at the period boundary, and a synchronised ALIGNWD phase slip.
module clkdiv_prog #(
  parameter int CNT_W       = 4,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             CLKI,
  input  logic             RSTN,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_VAL,
  input  logic             DIV_LD,
  input  logic             ALIGNWD,
  output logic             CDIVX,
  output logic             CDIV_STB,
  output logic             SLIP_ACK,
  output logic [CNT_W-1:0] DIV_ACT,
  output logic [CNT_W-1:0] PHASE
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

  // Divisors below 2 cannot produce a toggling output, so they are raised to 2.
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    if (v < MIN_DIV) begin
      clamp_div = MIN_DIV;
    end else begin
      clamp_div = v;
    end
  endfunction

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_pend;
  logic             r_cdivx;
  logic             r_stb;
  logic             r_ack;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_edge;
  logic             r_slip_req;

  logic [CNT_W:0]   w_hi;
  logic             w_wrap;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_rise;
  logic             w_slip;
  logic [CNT_W-1:0] w_ld_val;

  // One extra bit keeps (DIV_ACT+1) from overflowing at the maximum divisor.
  assign w_hi      = ({1'b0, r_div_act} + (CNT_W+1)'(1)) >> 1;
  assign w_wrap    = (r_cnt == (r_div_act - CNT_W'(1)));
  assign w_cnt_nxt = w_wrap ? {CNT_W{1'b0}} : (r_cnt + CNT_W'(1));
  assign w_rise    = r_sync2 & ~r_edge;
  assign w_slip    = r_slip_req | w_rise;
  assign w_ld_val  = clamp_div(DIV_VAL);

  // ALIGNWD synchroniser and edge flop run regardless of EN.
  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= ALIGNWD;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  // Divide counter, divisor update, slip execution and registered outputs.
  always_ff @(posedge CLKI or negedge RSTN) begin
    if (!RSTN) begin
      r_cnt      <= {CNT_W{1'b0}};
      r_div_act  <= DEF_DIV;
      r_pend     <= DEF_DIV;
      r_cdivx    <= 1'b0;
      r_stb      <= 1'b0;
      r_ack      <= 1'b0;
      r_slip_req <= 1'b0;
    end else begin
      if (DIV_LD) begin
        r_pend <= w_ld_val;
      end
      if (!EN) begin
        r_stb      <= 1'b0;
        r_ack      <= 1'b0;
        r_slip_req <= w_slip;
      end else if (w_slip) begin
        // A slip stretches the current period by one cycle, even on the wrap edge.
        r_stb      <= 1'b0;
        r_ack      <= 1'b1;
        r_slip_req <= 1'b0;
      end else begin
        r_cdivx    <= ({1'b0, r_cnt} < w_hi);
        r_stb      <= (r_cnt == {CNT_W{1'b0}});
        r_ack      <= 1'b0;
        r_slip_req <= 1'b0;
        r_cnt      <= w_cnt_nxt;
        if (w_wrap) begin
          r_div_act <= DIV_LD ? w_ld_val : r_pend;
        end
      end
    end
  end

  assign CDIVX    = r_cdivx;
  assign CDIV_STB = r_stb;
  assign SLIP_ACK = r_ack;
  assign DIV_ACT  = r_div_act;
  assign PHASE    = r_cnt;

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed-vector scoreboard bench for clkdiv_prog: the driver queues the expected
// outputs for each edge, and a monitor pops and compares them after each edge/reset.
module tb_clkdiv_prog;

  logic       CLKI = 1'b0;
  logic       RSTN;
  logic       EN;
  logic [3:0] DIV_VAL;
  logic       DIV_LD;
  logic       ALIGNWD;
  logic       CDIVX;
  logic       CDIV_STB;
  logic       SLIP_ACK;
  logic [3:0] DIV_ACT;
  logic [3:0] PHASE;

  typedef struct {
    int         id;
    logic       x;
    logic       s;
    logic       a;
    logic [3:0] d;
    logic [3:0] p;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  clkdiv_prog #(.CNT_W(4), .DEFAULT_DIV(4)) dut (
    .CLKI(CLKI), .RSTN(RSTN), .EN(EN), .DIV_VAL(DIV_VAL), .DIV_LD(DIV_LD),
    .ALIGNWD(ALIGNWD), .CDIVX(CDIVX), .CDIV_STB(CDIV_STB), .SLIP_ACK(SLIP_ACK),
    .DIV_ACT(DIV_ACT), .PHASE(PHASE)
  );

  always #5 CLKI = ~CLKI;

  task automatic push_exp(input logic x, input logic s, input logic a,
                          input logic [3:0] d, input logic [3:0] p);
    exp_t e;
    step_id++;
    e.id = step_id; e.x = x; e.s = s; e.a = a; e.d = d; e.p = p;
    q.push_back(e);
  endtask

  // Drive inputs at a falling edge, queue the outputs expected after the next rising edge.
  task automatic step(input logic en, input logic ld, input logic [3:0] val, input logic al,
                      input logic x, input logic s, input logic a,
                      input logic [3:0] d, input logic [3:0] p);
    EN = en; DIV_LD = ld; DIV_VAL = val; ALIGNWD = al;
    push_exp(x, s, a, d, p);
    @(negedge CLKI);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLKI or negedge RSTN);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (CDIVX !== e.x || CDIV_STB !== e.s || SLIP_ACK !== e.a ||
            DIV_ACT !== e.d || PHASE !== e.p) begin
          failures++;
          $display("FAIL step%0d: got cdivx=%b stb=%b ack=%b div=%0d phase=%0d, want cdivx=%b stb=%b ack=%b div=%0d phase=%0d",
                   e.id, CDIVX, CDIV_STB, SLIP_ACK, DIV_ACT, PHASE, e.x, e.s, e.a, e.d, e.p);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    RSTN = 1'b0; EN = 1'b0; DIV_LD = 1'b0; DIV_VAL = 4'd0; ALIGNWD = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 4'd4, 4'd0);
    repeat (2) @(negedge CLKI);
    RSTN = 1'b1;
    // reset release, divide by 4
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    // load 5 at PHASE=1, applied on the wrap edge
    step(1, 1, 4'd5, 0,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd5, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd5, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd5, 4'd2);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd5, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd5, 4'd4);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd5, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd5, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd5, 4'd2);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd5, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd5, 4'd4);
    // DIV_VAL=1 on the wrap edge: clamped to 2 and bypasses pending
    step(1, 1, 4'd1, 0,  0, 0, 0, 4'd2, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd2, 4'd1);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd2, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd2, 4'd1);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd2, 4'd0);
    // back to 4
    step(1, 1, 4'd4, 0,  1, 1, 0, 4'd2, 4'd1);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    // single slip: ack on 3rd edge, 5-cycle period
    step(1, 0, 4'd0, 1,  1, 1, 0, 4'd4, 4'd1);
    step(1, 0, 4'd0, 1,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  1, 0, 1, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    // slip on the wrap edge: PHASE holds 3 one extra cycle
    step(1, 0, 4'd0, 1,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 1,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 1, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    // EN low for 3 cycles extends the period by 3
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(0, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(0, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(0, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    // slip armed while EN low; second ALIGNWD edge dropped; DIV_LD captured while EN low
    step(1, 0, 4'd0, 1,  1, 0, 0, 4'd4, 4'd2);
    step(0, 0, 4'd0, 1,  1, 0, 0, 4'd4, 4'd2);
    step(0, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(0, 0, 4'd0, 1,  1, 0, 0, 4'd4, 4'd2);
    step(0, 0, 4'd0, 1,  1, 0, 0, 4'd4, 4'd2);
    step(0, 1, 4'd3, 0,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  1, 0, 1, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd3, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd3, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd3, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd3, 4'd0);
    // set DIV_ACT=7 then pending 3, then reset at PHASE=2
    step(1, 1, 4'd7, 0,  1, 1, 0, 4'd3, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd3, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd7, 4'd0);
    step(1, 1, 4'd3, 0,  1, 1, 0, 4'd7, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd7, 4'd2);
    push_exp(1'b0, 1'b0, 1'b0, 4'd4, 4'd0);
    #2 RSTN = 1'b0;
    repeat (2) @(negedge CLKI);
    RSTN = 1'b1;
    // pending 3 was discarded: DIV_ACT stays 4 through the first wrap
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    step(1, 0, 4'd0, 0,  1, 0, 0, 4'd4, 4'd2);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd3);
    step(1, 0, 4'd0, 0,  0, 0, 0, 4'd4, 4'd0);
    step(1, 0, 4'd0, 0,  1, 1, 0, 4'd4, 4'd1);
    @(negedge CLKI);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL leftover: %0d expected entries never compared, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
